// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared Wishbone widths, slave window size and responder FSM states
package wb_pkg;
    localparam int WB_DAT_W          = 32;
    localparam int WB_SEL_W          = 4;
    localparam int WB_ADR_W          = 32;
    localparam int SLAVE_WINDOW_BITS = 20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } wb_state_e;
endpackage

// File: rtl/wb_ram_bytelane.sv
// rtl/wb_ram_bytelane.sv - single-port 32-bit RAM with byte write enables and registered read
module wb_ram_bytelane
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  re,
    input  logic [WB_SEL_W-1:0]   we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WB_DAT_W-1:0]   wdata,
    output logic [WB_DAT_W-1:0]   rdata
);
    logic [WB_DAT_W-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < WB_SEL_W; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/wb_ram_slave.sv
// rtl/wb_ram_slave.sv - Wishbone classic RAM slave with wait states and error response
module wb_ram_slave
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wb_cyc_i,
    input  logic                wb_stb_i,
    input  logic                wb_we_i,
    input  logic [WB_ADR_W-1:0] wb_adr_i,
    input  logic [WB_SEL_W-1:0] wb_sel_i,
    input  logic [WB_DAT_W-1:0] wb_dat_i,
    output logic [WB_DAT_W-1:0] wb_dat_o,
    output logic                wb_ack_o,
    output logic                wb_err_o
);
    // Window bits above the RAM index must be zero for a good request.
    localparam logic [SLAVE_WINDOW_BITS-1:0] HI_MASK =
        ~((SLAVE_WINDOW_BITS'(1) << (ADDR_WIDTH + 2)) - SLAVE_WINDOW_BITS'(1));
    localparam logic [3:0] WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    wb_state_e state, state_next;
    logic [3:0] cnt, cnt_next;
    logic       commit;

    logic                  req, req_bad;
    logic [ADDR_WIDTH-1:0] idx_q, cur_idx;
    logic                  we_q, cur_we, bad_q, cur_bad;
    logic [WB_SEL_W-1:0]   sel_q, cur_sel;
    logic [WB_DAT_W-1:0]   dat_q, cur_dat;
    logic [WB_SEL_W-1:0]   ram_we;
    logic                  ram_re;
    logic [WB_DAT_W-1:0]   ram_rdata;
    logic                  dat_zero;
    logic                  unused_adr_hi;

    assign unused_adr_hi = &{1'b0, wb_adr_i[WB_ADR_W-1:SLAVE_WINDOW_BITS]};

    assign req     = wb_cyc_i & wb_stb_i;
    assign req_bad = (|wb_adr_i[1:0]) | (|(wb_adr_i[SLAVE_WINDOW_BITS-1:0] & HI_MASK));

    // With zero wait states the commit happens on the capture edge, so use live inputs in IDLE.
    assign cur_idx = (state == IDLE) ? wb_adr_i[ADDR_WIDTH+1:2] : idx_q;
    assign cur_we  = (state == IDLE) ? wb_we_i  : we_q;
    assign cur_sel = (state == IDLE) ? wb_sel_i : sel_q;
    assign cur_dat = (state == IDLE) ? wb_dat_i : dat_q;
    assign cur_bad = (state == IDLE) ? req_bad  : bad_q;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (WAIT_STATES == 0) begin
                        state_next = RESP;
                        commit     = 1'b1;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = WS_INIT;
                    end
                end
            end
            WAIT: begin
                if (!wb_cyc_i) begin
                    state_next = IDLE;
                end else if (cnt == 4'd0) begin
                    state_next = RESP;
                    commit     = 1'b1;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (rst) begin
            commit = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && req) begin
            idx_q <= wb_adr_i[ADDR_WIDTH+1:2];
            we_q  <= wb_we_i;
            sel_q <= wb_sel_i;
            dat_q <= wb_dat_i;
            bad_q <= req_bad;
        end
    end

    assign ram_we = (commit && cur_we && !cur_bad) ? cur_sel : '0;
    assign ram_re = commit && !cur_we && !cur_bad;

    wb_ram_bytelane #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .clk   (clk),
        .re    (ram_re),
        .we    (ram_we),
        .addr  (cur_idx),
        .wdata (cur_dat),
        .rdata (ram_rdata)
    );

    // RAM read register is never reset, so a flag forces the zero after reset or an error.
    always_ff @(posedge clk) begin
        if (rst) begin
            dat_zero <= 1'b1;
        end else if (commit) begin
            if (cur_bad) begin
                dat_zero <= 1'b1;
            end else if (!cur_we) begin
                dat_zero <= 1'b0;
            end
        end
    end

    assign wb_dat_o = dat_zero ? '0 : ram_rdata;
    assign wb_ack_o = (state == RESP) && !bad_q;
    assign wb_err_o = (state == RESP) && bad_q;
endmodule

// File: tb/tb_wb_ram_slave.sv
// tb/tb_wb_ram_slave.sv - directed self-checking bench for wb_ram_slave
module tb_wb_ram_slave;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  cyc = 3'b000;
    logic        stb = 1'b0;
    logic        bus_we = 1'b0;
    logic [31:0] bus_adr = '0;
    logic [3:0]  bus_sel = '0;
    logic [31:0] bus_dat = '0;
    logic [2:0]  ack, err;
    logic [31:0] rd [3];

    int vec = 0;
    int miscmp = 0;

    always #5 clk = ~clk;

    wb_ram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut_ws0 (
        .clk(clk), .rst(rst), .wb_cyc_i(cyc[0]), .wb_stb_i(stb), .wb_we_i(bus_we),
        .wb_adr_i(bus_adr), .wb_sel_i(bus_sel), .wb_dat_i(bus_dat),
        .wb_dat_o(rd[0]), .wb_ack_o(ack[0]), .wb_err_o(err[0]));

    wb_ram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(3)) dut_ws3 (
        .clk(clk), .rst(rst), .wb_cyc_i(cyc[1]), .wb_stb_i(stb), .wb_we_i(bus_we),
        .wb_adr_i(bus_adr), .wb_sel_i(bus_sel), .wb_dat_i(bus_dat),
        .wb_dat_o(rd[1]), .wb_ack_o(ack[1]), .wb_err_o(err[1]));

    wb_ram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(2)) dut_ws2 (
        .clk(clk), .rst(rst), .wb_cyc_i(cyc[2]), .wb_stb_i(stb), .wb_we_i(bus_we),
        .wb_adr_i(bus_adr), .wb_sel_i(bus_sel), .wb_dat_i(bus_dat),
        .wb_dat_o(rd[2]), .wb_ack_o(ack[2]), .wb_err_o(err[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miscmp++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transfer on lane k: checks latency 1+ws, ack/err choice, read data and one-cycle response.
    task automatic xfer(input int k, input int ws, input logic we, input logic [31:0] adr,
                        input logic [3:0] sel, input logic [31:0] dat,
                        input logic exp_err, input logic [31:0] exp_rd, input string tag);
        int lat;
        @(negedge clk);
        cyc[k] = 1'b1; stb = 1'b1; bus_we = we; bus_adr = adr; bus_sel = sel; bus_dat = dat;
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (ack[k] | err[k]) begin
                lat = c;
                break;
            end
        end
        chk({tag, " latency"}, 32'(lat), 32'(1 + ws));
        chk({tag, " ack/err"}, {30'd0, ack[k], err[k]}, {30'd0, ~exp_err, exp_err});
        if (!we) chk({tag, " rdata"}, rd[k], exp_rd);
        cyc[k] = 1'b0; stb = 1'b0;
        @(negedge clk);
        chk({tag, " single-cycle"}, {30'd0, ack[k], err[k]}, 32'd0);
    endtask

    initial begin
        logic seen;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset ws0", {ack[0], err[0], rd[0]}, 34'd0);
        chk("reset ws3", {ack[1], err[1], rd[1]}, 34'd0);
        chk("reset ws2", {ack[2], err[2], rd[2]}, 34'd0);

        xfer(0, 0, 1'b1, 32'h0000_0004, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0, "wr4");
        xfer(0, 0, 1'b0, 32'h0000_0004, 4'hF, 32'h0, 1'b0, 32'hDEAD_BEEF, "rd4");

        xfer(0, 0, 1'b1, 32'h0000_0008, 4'hF, 32'hFFFF_FFFF, 1'b0, 32'h0, "wr8 full");
        xfer(0, 0, 1'b1, 32'h0000_0008, 4'h5, 32'h1234_5678, 1'b0, 32'h0, "wr8 sel5");
        xfer(0, 0, 1'b0, 32'h0000_0008, 4'h0, 32'h0, 1'b0, 32'hFF34_FF78, "rd8 lanes");
        xfer(0, 0, 1'b1, 32'h0000_0008, 4'h0, 32'hAAAA_AAAA, 1'b0, 32'h0, "wr8 sel0");
        xfer(0, 0, 1'b0, 32'h0000_0008, 4'hF, 32'h0, 1'b0, 32'hFF34_FF78, "rd8 after sel0");

        xfer(1, 3, 1'b1, 32'h0000_0004, 4'hF, 32'h5A5A_5A5A, 1'b0, 32'h0, "ws3 wr");
        xfer(1, 3, 1'b0, 32'h0000_0004, 4'hF, 32'h0, 1'b0, 32'h5A5A_5A5A, "ws3 rd");

        xfer(0, 0, 1'b1, 32'h0000_0000, 4'hF, 32'hA5A5_A5A5, 1'b0, 32'h0, "wr0");
        xfer(0, 0, 1'b0, 32'h0000_0004, 4'hF, 32'h0, 1'b0, 32'hDEAD_BEEF, "rd4 again");
        xfer(0, 0, 1'b0, 32'h0000_1000, 4'hF, 32'h0, 1'b1, 32'h0, "oor rd");
        xfer(0, 0, 1'b1, 32'h0000_1000, 4'hF, 32'h5555_5555, 1'b1, 32'h0, "oor wr");
        xfer(0, 0, 1'b0, 32'h0000_0000, 4'hF, 32'h0, 1'b0, 32'hA5A5_A5A5, "rd0 untouched");
        xfer(0, 0, 1'b0, 32'h0000_0002, 4'hF, 32'h0, 1'b1, 32'h0, "misaligned");
        xfer(0, 0, 1'b1, 32'h0070_0010, 4'hF, 32'h1111_2222, 1'b0, 32'h0, "upper ignored wr");
        xfer(0, 0, 1'b0, 32'h0000_0010, 4'hF, 32'h0, 1'b0, 32'h1111_2222, "upper ignored rd");

        @(negedge clk);
        cyc[0] = 1'b1; stb = 1'b1; bus_we = 1'b0; bus_adr = 32'h0000_0004; bus_sel = 4'hF;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("b2b ack %0d", i), {31'd0, ack[0]}, 32'(i % 2));
            if (i % 2 == 1) chk($sformatf("b2b data %0d", i), rd[0], 32'hDEAD_BEEF);
        end
        cyc[0] = 1'b0; stb = 1'b0;
        @(negedge clk);

        xfer(2, 2, 1'b1, 32'h0000_0020, 4'hF, 32'hCAFE_F00D, 1'b0, 32'h0, "ws2 wr20");
        @(negedge clk);
        cyc[2] = 1'b1; stb = 1'b1; bus_we = 1'b1; bus_adr = 32'h0000_0020; bus_sel = 4'hF; bus_dat = 32'h0;
        @(negedge clk);
        cyc[2] = 1'b0; stb = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            seen = seen | ack[2] | err[2];
        end
        chk("abort no response", {31'd0, seen}, 32'd0);
        xfer(2, 2, 1'b0, 32'h0000_0020, 4'hF, 32'h0, 1'b0, 32'hCAFE_F00D, "abort target kept");

        xfer(2, 2, 1'b1, 32'h0000_0010, 4'hF, 32'h0BAD_C0DE, 1'b0, 32'h0, "ws2 wr10");
        @(negedge clk);
        cyc[2] = 1'b1; stb = 1'b1; bus_we = 1'b1; bus_adr = 32'h0000_0010; bus_sel = 4'hF; bus_dat = 32'hFFFF_FFFF;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; cyc[2] = 1'b0; stb = 1'b0;
        chk("rst state idle", 32'(dut_ws2.state), 32'(wb_pkg::IDLE));
        chk("rst dat zero", rd[2], 32'h0);
        seen = ack[2] | err[2];
        repeat (4) begin
            @(negedge clk);
            seen = seen | ack[2] | err[2];
        end
        chk("rst no response", {31'd0, seen}, 32'd0);
        xfer(2, 2, 1'b0, 32'h0000_0010, 4'hF, 32'h0, 1'b0, 32'h0BAD_C0DE, "rst write discarded");
        xfer(0, 0, 1'b0, 32'h0000_0004, 4'hF, 32'h0, 1'b0, 32'hDEAD_BEEF, "ram kept over rst");

        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end
endmodule
